// File: rtl/backscatter_pkg.sv
// Shared types and defaults for the backscatter
// transmit sequencer.
package backscatter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    SEND,
    GUARD
  } state_e;

  localparam int DEF_DELAY_CYCLES = 1000;
  localparam int DEF_BIT_CYCLES   = 40;
  localparam int DEF_GUARD_CYCLES = 100;

  // Bits needed to count 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/backscatter_tx_sequencer_if.sv
// Payload byte stream into the sequencer:
// data/valid/last from the source, ready pulse back.
interface backscatter_tx_sequencer_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );

endinterface

// File: rtl/backscatter_tx_sequencer_trigger_sync.sv
// Two-flop synchroniser for the envelope-detector
// trigger plus a registered rising-edge pulse.
module trigger_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Metastability chain, history flop, edge pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/backscatter_tx_sequencer.sv
// Trigger-delayed backscatter modulator: waits,
// shifts payload bytes LSB first, then guards.
module backscatter_tx_sequencer
  import backscatter_pkg::*;
#(
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger_signal,
  input  logic enable,
  backscatter_tx_sequencer_if.slave byte_if,
  output logic switch_enable,
  output logic phase_flip,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int WMAX =
    (DELAY_CYCLES > GUARD_CYCLES) ?
    DELAY_CYCLES : GUARD_CYCLES;
  localparam int WW = cnt_w(WMAX);
  localparam int BW = cnt_w(BIT_CYCLES);

  localparam logic [WW-1:0] DLY_LAST =
    WW'(DELAY_CYCLES - 1);
  localparam logic [WW-1:0] GRD_LAST =
    WW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(BIT_CYCLES - 1);

  state_e        state;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic [2:0]    bit_idx;
  logic [6:0]    sreg;
  logic          last_q;
  logic          trig_rise;

  trigger_sync u_sync (
    .clock (clock),
    .reset (reset),
    .din   (trigger_signal),
    .rise  (trig_rise)
  );

  assign busy = (state != IDLE);

  // Sequencer FSM; every output is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      wcnt               <= '0;
      bcnt               <= '0;
      bit_idx            <= '0;
      sreg               <= '0;
      last_q             <= 1'b0;
      switch_enable      <= 1'b0;
      phase_flip         <= 1'b0;
      done               <= 1'b0;
      underrun           <= 1'b0;
      byte_if.byte_ready <= 1'b0;
    end else begin
      done               <= 1'b0;
      underrun           <= 1'b0;
      byte_if.byte_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig_rise && enable) begin
            state <= WAIT_DELAY;
            wcnt  <= '0;
          end
        end
        WAIT_DELAY: begin
          if (!enable) begin
            state <= GUARD;
            wcnt  <= '0;
          end else if (wcnt != DLY_LAST) begin
            wcnt <= wcnt + WW'(1);
          end else if (byte_if.byte_valid) begin
            state              <= SEND;
            wcnt               <= '0;
            bcnt               <= '0;
            bit_idx            <= '0;
            sreg               <= byte_if.byte_data[7:1];
            last_q             <= byte_if.byte_last;
            phase_flip         <= byte_if.byte_data[0];
            switch_enable      <= 1'b1;
            byte_if.byte_ready <= 1'b1;
          end else begin
            state    <= GUARD;
            wcnt     <= '0;
            underrun <= 1'b1;
          end
        end
        SEND: begin
          if (!enable) begin
            state         <= GUARD;
            wcnt          <= '0;
            switch_enable <= 1'b0;
            phase_flip    <= 1'b0;
          end else if (bcnt != BIT_LAST) begin
            bcnt <= bcnt + BW'(1);
          end else if (bit_idx != 3'd7) begin
            bcnt       <= '0;
            bit_idx    <= bit_idx + 3'd1;
            phase_flip <= sreg[0];
            sreg       <= {1'b0, sreg[6:1]};
          end else if (last_q) begin
            state         <= GUARD;
            wcnt          <= '0;
            bcnt          <= '0;
            switch_enable <= 1'b0;
            phase_flip    <= 1'b0;
          end else if (byte_if.byte_valid) begin
            bcnt               <= '0;
            bit_idx            <= '0;
            sreg               <= byte_if.byte_data[7:1];
            last_q             <= byte_if.byte_last;
            phase_flip         <= byte_if.byte_data[0];
            byte_if.byte_ready <= 1'b1;
          end else begin
            state         <= GUARD;
            wcnt          <= '0;
            bcnt          <= '0;
            switch_enable <= 1'b0;
            phase_flip    <= 1'b0;
            underrun      <= 1'b1;
          end
        end
        GUARD: begin
          if (wcnt == GRD_LAST) begin
            state <= IDLE;
            wcnt  <= '0;
            done  <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
      endcase
    end
  end

endmodule
